// File: rtl/alu_op_sequencer.sv
// Execute-stage issue controller: single-cycle ALU ops plus an iterative
// shift-add multiplier, with valid/ready request and response handshakes.
module alu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       rd_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       rd_o,
  output logic             busy_o
);

  localparam int N   = WIDTH / MUL_BPC;
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  // Decoder ALU_Control encodings; 3'b111 is unassigned.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, partial, alu_res, result_q;
  logic [4:0]       rd_q;
  logic [SHW-1:0]   shamt;
  logic             accept, is_mul;

  assign req_ready_o = !flush_i && (state == IDLE || (state == DONE && rsp_ready_i));
  assign accept      = req_valid_i && req_ready_o;
  assign is_mul      = (ALUCtrl_i == ALU_MUL);
  assign shamt       = src2_i[SHW-1:0];
  assign busy_o      = (state == MUL);
  assign rsp_valid_o = (state == DONE);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_AND: alu_res = src1_i & src2_i;
      ALU_XOR: alu_res = src1_i ^ src2_i;
      ALU_SLL: alu_res = src1_i << shamt;
      ALU_ADD: alu_res = src1_i + src2_i;
      ALU_SUB: alu_res = src1_i - src2_i;
      ALU_SRA: alu_res = $signed(src1_i) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Sum of the MUL_BPC shifted multiplicand copies retired this step.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) next_state = is_mul ? MUL : DONE;
        MUL:  if (cnt == CW'(1)) next_state = DONE;
        DONE: begin
          if (accept)           next_state = is_mul ? MUL : DONE;
          else if (rsp_ready_i) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (flush_i) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      rd_q <= rd_i;
      if (is_mul) begin
        mcand  <= src1_i;
        mplier <= src2_i;
        acc    <= '0;
        cnt    <= N_CNT;
      end else begin
        result_q <= alu_res;
      end
    end else if (state == MUL) begin
      acc    <= acc + partial;
      mcand  <= mcand << MUL_BPC;
      mplier <= mplier >> MUL_BPC;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) result_q <= acc + partial;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scenario bench for alu_op_sequencer: expected results are queued when a
// request is driven and popped when the response is observed.
module tb_alu_op_sequencer;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_BAD = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, req_valid_i, rsp_ready_i;
  logic        req_ready_o, rsp_valid_o, busy_o;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] src1_i, src2_i, result_o;
  logic [4:0]  rd_i, rd_o;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t exp_v;

  alu_op_sequencer #(.WIDTH(32), .MUL_BPC(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .ALUCtrl_i(ALUCtrl_i), .src1_i(src1_i), .src2_i(src2_i), .rd_i(rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .result_o(result_o), .rd_o(rd_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      OP_AND: return a & b;
      OP_XOR: return a ^ b;
      OP_SLL: return a << b[4:0];
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_SRA: return $unsigned($signed(a) >>> b[4:0]);
      OP_MUL: begin p = 64'(a) * 64'(b); return p[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  // Caller is at a negedge; request is presented and the expectation queued.
  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    req_valid_i = 1'b1;
    ALUCtrl_i   = op;
    src1_i      = a;
    src2_i      = b;
    rd_i        = rd;
    e.res = model(op, a, b);
    e.rd  = rd;
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic pop_expected;
    if (sb.size() > 0) exp_v = sb.pop_front();
    else begin exp_v.res = 32'hDEAD_BEEF; exp_v.rd = 5'h1F; end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    ALUCtrl_i = OP_AND; src1_i = '0; src2_i = '0; rd_i = '0;
    step(); step();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", result_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    rst_i = 1'b0;
    step();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL idle_req_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_add;
    drive_req(OP_ADD, 32'd5, 32'd7, 5'd3);
    step();
    req_valid_i = 1'b0;
    pop_expected();
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %b want 1", rsp_valid_o); end
    checks++; if (result_o !== exp_v.res) begin errors++; $display("[TB] FAIL add_result: got %h want %h", result_o, exp_v.res); end
    checks++; if (rd_o !== exp_v.rd) begin errors++; $display("[TB] FAIL add_rd: got %0d want %0d", rd_o, exp_v.rd); end
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL add_idle_after: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_back_to_back;
    drive_req(OP_SUB, 32'd0, 32'd1, 5'd1);
    step();
    pop_expected();
    checks++; if (result_o !== exp_v.res || rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sub: got %h/%b want %h/1", result_o, rsp_valid_o, exp_v.res); end
    drive_req(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd2);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready: got %b want 1", req_ready_o); end
    step();
    pop_expected();
    checks++; if (result_o !== exp_v.res || rd_o !== exp_v.rd || rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_xor: got %h rd %0d want %h rd %0d", result_o, rd_o, exp_v.res, exp_v.rd); end
    // Random single-cycle stream with no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive_req(3'($urandom_range(0, 5)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      step();
      pop_expected();
      checks++; if (result_o !== exp_v.res || rd_o !== exp_v.rd || rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rand%0d: got %h rd %0d want %h rd %0d", i, result_o, rd_o, exp_v.res, exp_v.rd); end
    end
    req_valid_i = 1'b0;
    step();
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
    int cyc;
    int busy_cnt;
    drive_req(OP_MUL, a, b, 5'd5);
    step();
    req_valid_i = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL %s_ready_busy: got %b want 0", tag, req_ready_o); end
    while (rsp_valid_o !== 1'b1 && cyc < 100) begin
      if (busy_o === 1'b1) busy_cnt++;
      step();
      cyc++;
    end
    pop_expected();
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL %s_latency: got %0d want 33", tag, cyc); end
    checks++; if (busy_cnt !== 32) begin errors++; $display("[TB] FAIL %s_busy_cycles: got %0d want 32", tag, busy_cnt); end
    checks++; if (result_o !== exp_v.res) begin errors++; $display("[TB] FAIL %s_result: got %h want %h", tag, result_o, exp_v.res); end
    step();
  endtask

  task automatic test_mul;
    run_mul(32'h0001_0001, 32'h0001_0001, "mul_fixed");
    run_mul($urandom, $urandom, "mul_rand");
  endtask

  task automatic test_stall;
    rsp_ready_i = 1'b0;
    drive_req(OP_SRA, 32'h8000_0000, 32'd4, 5'd9);
    step();
    req_valid_i = 1'b0;
    pop_expected();
    for (int i = 0; i < 5; i++) begin
      checks++; if (result_o !== exp_v.res || rd_o !== exp_v.rd || rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold%0d: got %h/%b want %h/1", i, result_o, rsp_valid_o, exp_v.res); end
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready%0d: got %b want 0", i, req_ready_o); end
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ready: got %b want 1", req_ready_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_drained: got %b want 0", rsp_valid_o); end
  endtask

  task automatic abort_mul(input bit use_reset);
    bit seen;
    req_valid_i = 1'b1; ALUCtrl_i = OP_MUL; src1_i = 32'd3; src2_i = 32'd4; rd_i = 5'd7;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 9; i++) step();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before: got %b want 1", busy_o); end
    if (use_reset) rst_i = 1'b1;
    else flush_i = 1'b1;
    #1;
    if (!use_reset) begin
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b want 0", req_ready_o); end
    end
    step();
    rst_i = 1'b0; flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: busy %b valid %b want 0/0", busy_o, rsp_valid_o); end
    if (use_reset) begin
      checks++; if (result_o !== 32'h0 || rd_o !== 5'd0) begin errors++; $display("[TB] FAIL abort_reset_outputs: got %h rd %0d want 0 rd 0", result_o, rd_o); end
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid_o === 1'b1) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_rsp: got %b want 0", seen); end
    drive_req(OP_ADD, 32'd100, 32'd23, 5'd4);
    step();
    req_valid_i = 1'b0;
    pop_expected();
    checks++; if (result_o !== exp_v.res || rd_o !== exp_v.rd || rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL abort_next_add: got %h rd %0d want %h rd %0d", result_o, rd_o, exp_v.res, exp_v.rd); end
    step();
  endtask

  task automatic test_flush;
    abort_mul(1'b0);
    abort_mul(1'b1);
  endtask

  task automatic test_edge_codes;
    drive_req(OP_SLL, 32'd1, 32'd33, 5'd10);
    step();
    pop_expected();
    checks++; if (result_o !== 32'd2) begin errors++; $display("[TB] FAIL sll_mask: got %h want 2", result_o); end
    drive_req(OP_BAD, 32'd5, 32'd6, 5'd11);
    step();
    req_valid_i = 1'b0;
    pop_expected();
    checks++; if (result_o !== 32'd0 || rd_o !== 5'd11 || rsp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL undef_code: got %h rd %0d want 0 rd 11", result_o, rd_o); end
    step();
    checks++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL sb_leftover: got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_stall();
    test_flush();
    test_edge_codes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
